// File: rtl/ddr_pkg.sv
// Shared command codes, FSM state type and default widths for the DDR
// command responder and its read tracker.
package ddr_pkg;

   localparam logic [3:0] CMD_READ  = 4'b0011;
   localparam logic [3:0] CMD_WRITE = 4'b0100;

   localparam int DEF_ADDR_W          = 25;
   localparam int DEF_DATA_W          = 128;
   localparam int DEF_MAX_OUTSTANDING = 4;
   localparam int DEF_RD_TIMEOUT      = 255;

   typedef enum logic [1:0] {
      IDLE,
      CMD,
      WDATA
   } state_t;

   function automatic logic is_legal_cmd(input logic [3:0] code);
      return (code == CMD_READ) || (code == CMD_WRITE);
   endfunction

endpackage

// File: rtl/ddr_rd_tracker.sv
// Counts reads in flight and registers returned read data toward the arbiter.
// Optional DDR_RD_TIMEOUT_EN synthesises a zero-data return for a lost read.
module ddr_rd_tracker
   import ddr_pkg::*;
#(
   parameter int DATA_W          = DEF_DATA_W,
   parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
   parameter int RD_TIMEOUT      = DEF_RD_TIMEOUT
)
(
   input  logic              clk_133M,
   input  logic              rst_133M,
   input  logic              rd_issue,
   input  logic              mem_rd_valid,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic [DATA_W-1:0] ddr_rd_data,
   output logic              ddr_data_valid,
   output logic              at_max_next,
   output logic              rd_err
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

   logic [CNT_W-1:0] outstanding;
   logic [CNT_W-1:0] outstanding_next;
   logic             timeout_hit;
   logic             ret_dec;

`ifdef DDR_RD_TIMEOUT_EN
   localparam int TMR_W = $clog2(RD_TIMEOUT + 1);

   logic [TMR_W-1:0] rd_timer;

   // Timer only ages while a read is owed and nothing is coming back.
   always_ff @(posedge clk_133M) begin
      if (rst_133M || mem_rd_valid || (outstanding == '0) || timeout_hit)
         rd_timer <= '0;
      else
         rd_timer <= rd_timer + TMR_W'(1);
   end

   assign timeout_hit = (outstanding != '0) && !mem_rd_valid &&
                        (rd_timer == TMR_W'(RD_TIMEOUT - 1));
`else
   localparam int unused_rd_timeout = RD_TIMEOUT;

   assign timeout_hit = 1'b0;
`endif

   // A return with nothing outstanding is forwarded but never drives the count below zero.
   assign ret_dec = (mem_rd_valid || timeout_hit) && (outstanding != '0);
   assign rd_err  = (mem_rd_valid && (outstanding == '0)) || timeout_hit;

   always_comb begin
      outstanding_next = outstanding;
      if (rd_issue && !ret_dec)
         outstanding_next = outstanding + CNT_W'(1);
      else if (!rd_issue && ret_dec)
         outstanding_next = outstanding - CNT_W'(1);
   end

   assign at_max_next = (outstanding_next == CNT_W'(MAX_OUTSTANDING));

   always_ff @(posedge clk_133M) begin
      if (rst_133M) begin
         outstanding    <= '0;
         ddr_data_valid <= 1'b0;
         ddr_rd_data    <= '0;
      end else begin
         outstanding    <= outstanding_next;
         ddr_data_valid <= mem_rd_valid || timeout_hit;
         if (mem_rd_valid)
            ddr_rd_data <= mem_rd_data;
         else if (timeout_hit)
            ddr_rd_data <= '0;
      end
   end

endmodule

// File: rtl/ddr_cmd_responder.sv
// Target end of the DDR request path: turns arbiter commands into controller
// transactions. Define DDR_RD_TIMEOUT_EN to enable read-return timeouts.
module ddr_cmd_responder
   import ddr_pkg::*;
#(
   parameter int ADDR_W          = DEF_ADDR_W,
   parameter int DATA_W          = DEF_DATA_W,
   parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
   parameter int RD_TIMEOUT      = DEF_RD_TIMEOUT
)
(
   input  logic              clk_133M,
   input  logic              rst_133M,
   input  logic [3:0]        cmd,
   input  logic              cmd_valid,
   input  logic [ADDR_W-1:0] ddr_address,
   input  logic [DATA_W-1:0] ddr_wr_data,
   output logic              cmd_busy,
   output logic [DATA_W-1:0] ddr_rd_data,
   output logic              ddr_data_valid,
   output logic              cmd_err,
   output logic [3:0]        mem_cmd,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_cmd_valid,
   input  logic              mem_cmd_rdy,
   output logic [DATA_W-1:0] mem_wr_data,
   input  logic              mem_datain_rdy,
   input  logic [DATA_W-1:0] mem_rd_data,
   input  logic              mem_rd_valid,
   input  logic              init_done
);

   state_t            state;
   state_t            state_next;
   logic              accept;
   logic              legal;
   logic              rd_issue;
   logic              at_max_next;
   logic              rd_err;
   logic [3:0]        hold_cmd;
   logic [ADDR_W-1:0] hold_addr;
   logic [DATA_W-1:0] hold_data;

   assign accept   = cmd_valid && (state == IDLE) && !cmd_busy;
   assign legal    = is_legal_cmd(cmd);
   assign rd_issue = (state == CMD) && mem_cmd_rdy && (hold_cmd == CMD_READ);

   assign mem_cmd     = hold_cmd;
   assign mem_addr    = hold_addr;
   assign mem_wr_data = hold_data;

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept && legal) state_next = CMD;
         CMD:     if (mem_cmd_rdy) state_next = (hold_cmd == CMD_READ) ? IDLE : WDATA;
         WDATA:   if (mem_datain_rdy) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Busy is computed from next-cycle state so the arbiter sees it aligned with the FSM.
   always_ff @(posedge clk_133M) begin
      if (rst_133M) begin
         state         <= IDLE;
         cmd_busy      <= 1'b1;
         cmd_err       <= 1'b0;
         mem_cmd_valid <= 1'b0;
         hold_cmd      <= '0;
         hold_addr     <= '0;
         hold_data     <= '0;
      end else begin
         state         <= state_next;
         mem_cmd_valid <= (state_next == CMD);
         cmd_busy      <= !init_done || accept || (state_next != IDLE) || at_max_next;
         cmd_err       <= (accept && !legal) || (cmd_valid && cmd_busy) || rd_err;
         if (accept && legal) begin
            hold_cmd  <= cmd;
            hold_addr <= ddr_address;
            hold_data <= ddr_wr_data;
         end
      end
   end

   ddr_rd_tracker #(
      .DATA_W          (DATA_W),
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .RD_TIMEOUT      (RD_TIMEOUT)
   ) u_rd_tracker (
      .clk_133M       (clk_133M),
      .rst_133M       (rst_133M),
      .rd_issue       (rd_issue),
      .mem_rd_valid   (mem_rd_valid),
      .mem_rd_data    (mem_rd_data),
      .ddr_rd_data    (ddr_rd_data),
      .ddr_data_valid (ddr_data_valid),
      .at_max_next    (at_max_next),
      .rd_err         (rd_err)
   );

endmodule
